// File: rtl/ps2_cursor_pkg.sv
// Shared constants and types for the PS/2 cursor tracker.
package ps2_cursor_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_CLAMP = 2'd2;
  localparam logic [1:0] ST_DRAW  = 2'd3;

  // Default screen geometry
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  // Button bit positions inside btn_in / btn_state / btn_press
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;

  // One decoded mouse packet
  typedef struct packed {
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [2:0]        btn;
  } pkt_t;

endpackage

// File: rtl/cursor_axis_clamp.sv
// Clamps a signed candidate coordinate into the unsigned range [0, MAX].
module cursor_axis_clamp #(
  parameter int W   = 10,
  parameter int MAX = 639,
  parameter int SW  = 12
) (
  input  logic signed [SW-1:0] sum_i,
  output logic [W-1:0]         pos_o
);

  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);

  // Negative sums pin to 0, anything past the edge pins to MAX.
  always_comb begin
    if (sum_i[SW-1])        pos_o = '0;
    else if (sum_i > MAX_S) pos_o = W'(MAX);
    else                    pos_o = sum_i[W-1:0];
  end

endmodule

// File: rtl/ps2_cursor_tracker.sv
// Absolute, screen-clamped cursor from PS/2 relative packets, with button
// edge detection and a req/ack draw request while the left button is held.
module ps2_cursor_tracker
  import ps2_cursor_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int SENS_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_valid,
  input  logic signed [8:0] delta_x,
  input  logic signed [8:0] delta_y,
  input  logic [2:0]        btn_in,
  output logic [XW-1:0]     cursor_x,
  output logic [YW-1:0]     cursor_y,
  output logic [2:0]        btn_state,
  output logic [2:0]        btn_press,
  output logic              pos_valid,
  output logic              draw_req,
  input  logic              draw_ack,
  output logic              pkt_dropped
);

  // Sum width: widest axis + sign bit + one bit of headroom + sensitivity shift.
  localparam int SW = ((XW > YW) ? XW : YW) + SENS_SHIFT + 2;

  logic [1:0]        state_q, state_d;
  pkt_t              work_q, work_d;
  pkt_t              pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic signed [SW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [XW-1:0]     cursor_x_q, cursor_x_d;
  logic [YW-1:0]     cursor_y_q, cursor_y_d;
  logic [2:0]        btn_state_q, btn_state_d;
  logic [2:0]        btn_press_q, btn_press_d;
  logic              pos_valid_q, pos_valid_d;
  logic              draw_req_q, draw_req_d;
  logic              pkt_dropped_q, pkt_dropped_d;

  pkt_t              pkt_in;
  logic signed [SW-1:0] dx_ext, dy_ext, cx_ext, cy_ext;
  logic [XW-1:0]     clamp_x;
  logic [YW-1:0]     clamp_y;

  assign pkt_in = '{dx: delta_x, dy: delta_y, btn: btn_in};

  assign dx_ext = $signed({{(SW-9){work_q.dx[8]}}, work_q.dx}) <<< SENS_SHIFT;
  assign dy_ext = $signed({{(SW-9){work_q.dy[8]}}, work_q.dy}) <<< SENS_SHIFT;
  assign cx_ext = $signed({{(SW-XW){1'b0}}, cursor_x_q});
  assign cy_ext = $signed({{(SW-YW){1'b0}}, cursor_y_q});

  cursor_axis_clamp #(.W(XW), .MAX(H_RES-1), .SW(SW)) u_clamp_x (
    .sum_i (sx_q),
    .pos_o (clamp_x)
  );

  cursor_axis_clamp #(.W(YW), .MAX(V_RES-1), .SW(SW)) u_clamp_y (
    .sum_i (sy_q),
    .pos_o (clamp_y)
  );

  // FSM sequencing, pending-buffer management and output pulse generation.
  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    cursor_x_d    = cursor_x_q;
    cursor_y_d    = cursor_y_q;
    btn_state_d   = btn_state_q;
    btn_press_d   = '0;
    pos_valid_d   = 1'b0;
    draw_req_d    = draw_req_q;
    pkt_dropped_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Buffered packet is older, so it goes first; a same-cycle arrival refills the slot.
        if (pend_full_q) begin
          work_d  = pend_q;
          state_d = ST_CALC;
          if (pkt_valid) pend_d = pkt_in;
          else           pend_full_d = 1'b0;
        end else if (pkt_valid) begin
          work_d  = pkt_in;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // PS/2 Y is positive-up while screen rows grow downward.
        sx_d    = cx_ext + dx_ext;
        sy_d    = cy_ext - dy_ext;
        state_d = ST_CLAMP;
      end
      ST_CLAMP: begin
        cursor_x_d  = clamp_x;
        cursor_y_d  = clamp_y;
        btn_state_d = work_q.btn;
        btn_press_d = work_q.btn & ~btn_state_q;
        pos_valid_d = 1'b1;
        state_d     = work_q.btn[BTN_L] ? ST_DRAW : ST_IDLE;
      end
      ST_DRAW: begin
        // Ack only counts once the request is actually visible downstream.
        if (draw_req_q && draw_ack) begin
          draw_req_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          draw_req_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Packets arriving while busy: keep the oldest, report the overflow.
    if (state_q != ST_IDLE && pkt_valid) begin
      if (!pend_full_q) begin
        pend_d      = pkt_in;
        pend_full_d = 1'b1;
      end else begin
        pkt_dropped_d = 1'b1;
      end
    end
  end

  // State registers; reset parks the cursor at screen centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      work_q        <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      sx_q          <= '0;
      sy_q          <= '0;
      cursor_x_q    <= XW'(H_RES / 2);
      cursor_y_q    <= YW'(V_RES / 2);
      btn_state_q   <= '0;
      btn_press_q   <= '0;
      pos_valid_q   <= 1'b0;
      draw_req_q    <= 1'b0;
      pkt_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      cursor_x_q    <= cursor_x_d;
      cursor_y_q    <= cursor_y_d;
      btn_state_q   <= btn_state_d;
      btn_press_q   <= btn_press_d;
      pos_valid_q   <= pos_valid_d;
      draw_req_q    <= draw_req_d;
      pkt_dropped_q <= pkt_dropped_d;
    end
  end

  assign cursor_x    = cursor_x_q;
  assign cursor_y    = cursor_y_q;
  assign btn_state   = btn_state_q;
  assign btn_press   = btn_press_q;
  assign pos_valid   = pos_valid_q;
  assign draw_req    = draw_req_q;
  assign pkt_dropped = pkt_dropped_q;

endmodule
